// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants, FSM state type and index helper for rr_arbiter4
package arb_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Binary index of a one-hot vector; returns 0 for an all-zero vector.
   function automatic logic [IDX_W-1:0] onehot2idx(input logic [N_REQ-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) begin
            idx = IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating-priority picker over four requests
//   i_req      : request vector, bit i = requester i
//   i_ptr      : index that gets highest priority, then i_ptr+1, ... mod 4
//   i_mask_idx : requester excluded from the search when i_mask_en is set
//   i_mask_en  : enables the exclusion
//   o_pick_oh  : one-hot winner, or zero
//   o_pick_idx : binary index of the winner, 0 when none
//   o_pick_any : a winner exists
module rr_pick4
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   input  logic [IDX_W-1:0] i_mask_idx,
   input  logic             i_mask_en,
   output logic [N_REQ-1:0] o_pick_oh,
   output logic [IDX_W-1:0] o_pick_idx,
   output logic             o_pick_any
);

   logic [N_REQ-1:0] w_mask;
   logic [N_REQ-1:0] w_elig;
   logic [IDX_W-1:0] w_cand;
   logic [IDX_W-1:0] w_idx;
   logic             w_found;

   assign w_mask = i_mask_en ? (N_REQ'(1) << i_mask_idx) : '0;
   assign w_elig = i_req & ~w_mask;

   // Walk the candidates in priority order; the 2-bit add wraps mod 4.
   always_comb begin
      w_cand  = '0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         w_cand = i_ptr + IDX_W'(k);
         if (!w_found && w_elig[w_cand]) begin
            w_found = 1'b1;
            w_idx   = w_cand;
         end
      end
   end

   assign o_pick_any = w_found;
   assign o_pick_idx = w_idx;
   assign o_pick_oh  = w_found ? (N_REQ'(1) << w_idx) : '0;

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter with hold-limit preemption
//   i_clk         : rising-edge clock
//   i_rst         : synchronous active-high reset
//   i_en          : gates issuing of new grants; an existing grant is kept
//   i_req         : level-sensitive request vector
//   o_grant       : registered one-hot grant or zero
//   o_grant_idx   : binary index of o_grant, 0 when no grant
//   o_grant_valid : o_grant != 0
//   o_preempt     : single-cycle pulse in the cycle a grant was cut by the hold limit
module rr_arbiter4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 8
)
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [N_REQ-1:0] i_req,
   output logic [N_REQ-1:0] o_grant,
   output logic [IDX_W-1:0] o_grant_idx,
   output logic             o_grant_valid,
   output logic             o_preempt
);

   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;
   localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

   arb_state_t        r_state;
   logic [N_REQ-1:0]  r_grant;
   logic [IDX_W-1:0]  r_ptr;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic              r_preempt;

   arb_state_t        w_state_nxt;
   logic [N_REQ-1:0]  w_grant_nxt;
   logic [IDX_W-1:0]  w_ptr_nxt;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic              w_preempt_nxt;

   logic [IDX_W-1:0]  w_grant_idx;
   logic [IDX_W-1:0]  w_next_ptr;
   logic [IDX_W-1:0]  w_pick_ptr;
   logic              w_in_grant;
   logic [N_REQ-1:0]  w_pick_oh;
   logic [IDX_W-1:0]  w_pick_idx;
   logic              w_pick_any;

   assign w_grant_idx = onehot2idx(r_grant);
   assign w_next_ptr  = w_grant_idx + IDX_W'(1);
   assign w_in_grant  = (r_state == GRANT);

   // While granting, the only search that matters is the back-to-back one on
   // release, which starts just after the owner and excludes it.
   assign w_pick_ptr  = w_in_grant ? w_next_ptr : r_ptr;

   rr_pick4 u_pick (
      .i_req      (i_req),
      .i_ptr      (w_pick_ptr),
      .i_mask_idx (w_grant_idx),
      .i_mask_en  (w_in_grant),
      .o_pick_oh  (w_pick_oh),
      .o_pick_idx (w_pick_idx),
      .o_pick_any (w_pick_any)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_ptr      <= '0;
         r_hold_cnt <= '0;
         r_preempt  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_ptr      <= w_ptr_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_preempt  <= w_preempt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_ptr_nxt     = r_ptr;
      w_hold_nxt    = r_hold_cnt;
      w_preempt_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            w_grant_nxt = '0;
            w_hold_nxt  = '0;
            if (i_en && w_pick_any) begin
               w_grant_nxt = w_pick_oh;
               w_hold_nxt  = HOLD_ONE;
               w_state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (!i_req[w_grant_idx]) begin
               // Release takes precedence over the hold limit.
               w_ptr_nxt = w_next_ptr;
               if (i_en && w_pick_any) begin
                  w_grant_nxt = w_pick_oh;
                  w_hold_nxt  = HOLD_ONE;
               end else begin
                  w_grant_nxt = '0;
                  w_hold_nxt  = '0;
                  w_state_nxt = IDLE;
               end
            end else if ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LIMIT)) begin
               w_grant_nxt   = '0;
               w_hold_nxt    = '0;
               w_preempt_nxt = 1'b1;
               w_ptr_nxt     = w_next_ptr;
               w_state_nxt   = IDLE;
            end else if (r_hold_cnt != HOLD_SAT) begin
               w_hold_nxt = r_hold_cnt + HOLD_ONE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_hold_nxt  = '0;
         end
      endcase
   end

   assign o_grant       = r_grant;
   assign o_grant_idx   = w_grant_idx;
   assign o_grant_valid = |r_grant;
   assign o_preempt     = r_preempt;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - scoreboard bench for rr_arbiter4 with three hold-limit settings
module tb_rr_arbiter4;

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] req;

   logic [3:0] g0, g1, g2;
   logic [1:0] i0, i1, i2;
   logic       v0, v1, v2;
   logic       p0, p1, p2;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   typedef struct {
      int         due;
      int         dut;
      logic [3:0] g;
      logic       p;
      string      nm;
   } exp_t;

   exp_t sb[$];

   // DUT 0: default limit 16, DUT 1: limit 4, DUT 2: limit 3. All share stimulus.
   rr_arbiter4 #(.MAX_HOLD(16), .HOLD_W(8)) u_d0 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req),
      .o_grant(g0), .o_grant_idx(i0), .o_grant_valid(v0), .o_preempt(p0));
   rr_arbiter4 #(.MAX_HOLD(4), .HOLD_W(8)) u_d1 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req),
      .o_grant(g1), .o_grant_idx(i1), .o_grant_valid(v1), .o_preempt(p1));
   rr_arbiter4 #(.MAX_HOLD(3), .HOLD_W(8)) u_d2 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req),
      .o_grant(g2), .o_grant_idx(i2), .o_grant_valid(v2), .o_preempt(p2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [1:0] exp_idx(input logic [3:0] g);
      case (g)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // Monitor: pops every expectation that falls due at this negedge.
   logic [3:0] m_g;
   logic [1:0] m_i;
   logic       m_v, m_p;
   exp_t       m_e;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due == cyc) begin
         m_e = sb.pop_front();
         case (m_e.dut)
            0:       begin m_g = g0; m_i = i0; m_v = v0; m_p = p0; end
            1:       begin m_g = g1; m_i = i1; m_v = v1; m_p = p1; end
            default: begin m_g = g2; m_i = i2; m_v = v2; m_p = p2; end
         endcase
         total++;
         if ({m_g, m_i, m_v, m_p} !== {m_e.g, exp_idx(m_e.g), (m_e.g != 4'b0000), m_e.p}) begin
            bad++;
            $display("FAIL %s (dut%0d cyc %0d): got grant=%b idx=%0d valid=%b preempt=%b, want grant=%b idx=%0d valid=%b preempt=%b",
                     m_e.nm, m_e.dut, cyc, m_g, m_i, m_v, m_p,
                     m_e.g, exp_idx(m_e.g), (m_e.g != 4'b0000), m_e.p);
         end
      end
   end

   // Drive one cycle of inputs and queue the response expected after the next edge.
   task automatic step(input logic r, input logic e, input logic [3:0] q,
                       input int d, input logic [3:0] g, input logic p, input string nm);
      exp_t x;
      rst = r;
      en  = e;
      req = q;
      x.due = cyc + 1;
      x.dut = d;
      x.g   = g;
      x.p   = p;
      x.nm  = nm;
      sb.push_back(x);
      @(negedge clk);
   endtask

   task automatic reset_all(input string nm);
      exp_t x;
      rst = 1'b1;
      en  = 1'b0;
      req = 4'b0000;
      for (int d = 0; d < 3; d++) begin
         x.due = cyc + 1;
         x.dut = d;
         x.g   = 4'b0000;
         x.p   = 1'b0;
         x.nm  = nm;
         sb.push_back(x);
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      req = 4'b0000;
      @(negedge clk);
      reset_all("reset_state");

      // Single request
      step(0, 1, 4'b0100, 0, 4'b0100, 0, "single_grant");
      step(0, 1, 4'b0100, 0, 4'b0100, 0, "single_hold");
      step(0, 1, 4'b0000, 0, 4'b0000, 0, "single_release");
      step(0, 1, 4'b0000, 0, 4'b0000, 0, "single_idle");

      // Rotation with back-to-back handover
      reset_all("rot_reset");
      step(0, 1, 4'b1111, 0, 4'b0001, 0, "rot_0");
      step(0, 1, 4'b1110, 0, 4'b0010, 0, "rot_1");
      step(0, 1, 4'b1101, 0, 4'b0100, 0, "rot_2");
      step(0, 1, 4'b1011, 0, 4'b1000, 0, "rot_3");
      step(0, 1, 4'b0111, 0, 4'b0001, 0, "rot_wrap");
      step(0, 1, 4'b1111, 0, 4'b0001, 0, "rot_hold");

      // Hold limit of 4
      reset_all("hl_reset");
      step(0, 1, 4'b0011, 1, 4'b0001, 0, "hl_c1");
      step(0, 1, 4'b0011, 1, 4'b0001, 0, "hl_c2");
      step(0, 1, 4'b0011, 1, 4'b0001, 0, "hl_c3");
      step(0, 1, 4'b0011, 1, 4'b0001, 0, "hl_c4");
      step(0, 1, 4'b0011, 1, 4'b0000, 1, "hl_preempt");
      step(0, 1, 4'b0011, 1, 4'b0010, 0, "hl_next");
      step(0, 1, 4'b0011, 1, 4'b0010, 0, "hl_next_hold");

      // Enable gating
      reset_all("en_reset");
      step(0, 1, 4'b0010, 0, 4'b0010, 0, "en_grant");
      step(0, 1, 4'b1010, 0, 4'b0010, 0, "en_hold");
      step(0, 0, 4'b1000, 0, 4'b0000, 0, "en_release_gated");
      step(0, 0, 4'b1000, 0, 4'b0000, 0, "en_stay_idle");
      step(0, 1, 4'b1000, 0, 4'b1000, 0, "en_raised");

      // Reset mid-grant, pointer returns to 0
      step(0, 1, 4'b1000, 0, 4'b1000, 0, "rm_hold");
      step(1, 1, 4'b1001, 0, 4'b0000, 0, "rm_reset");
      step(0, 1, 4'b1001, 0, 4'b0001, 0, "rm_ptr0");

      // Release coinciding with hold limit of 3
      reset_all("col_reset");
      step(0, 1, 4'b0011, 2, 4'b0001, 0, "col_c1");
      step(0, 1, 4'b0011, 2, 4'b0001, 0, "col_c2");
      step(0, 1, 4'b0011, 2, 4'b0001, 0, "col_c3");
      step(0, 1, 4'b0010, 2, 4'b0010, 0, "col_release_wins");
      step(0, 1, 4'b0010, 2, 4'b0010, 0, "col_after");

      rst = 1'b0;
      en  = 1'b0;
      req = 4'b0000;
      repeat (3) @(negedge clk);

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that produces a registered one-hot grant vector plus its 2-bit index.
- Sits directly upstream of the 4-to-2 one-hot encoder stage. grant/grant_valid drive that stage's din/en, so din is always a legal one-hot code or zero.
- Holds a grant while its requester keeps req high. An optional hold-limit counter forces preemption so one requester cannot starve the others.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles a grant may be held; 0 disables the limit (legal range 0..255).
- HOLD_W, 8, width of the hold counter; must satisfy MAX_HOLD <= 2**HOLD_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  when low, no new grant is issued; an existing grant is not revoked.
- req  in  4  request vector; bit i is requester i, level-sensitive.
- grant  out  4  registered one-hot grant, or 4'b0000.
- grant_idx  out  2  binary index of the granted requester; 0 when grant is 0.
- grant_valid  out  1  high exactly when grant != 0.
- preempt  out  1  one-cycle pulse in the cycle grant is cleared by the hold limit.

Behaviour:
- Reset (synchronous, overrides all else):
  - grant=0, grant_idx=0, grant_valid=0, preempt=0.
  - state=IDLE, ptr=0 (priority order 0,1,2,3), hold_cnt=0.
  - Reset asserted mid-grant drops the grant on the next edge.
- All outputs are registered. Latency from req sampled to grant visible is 1 cycle.
- Pick function: choose the first set bit of req scanning ptr, ptr+1, ... mod 4.
- State IDLE:
  - If en && |req, load grant=onehot(pick), set grant_idx and grant_valid, hold_cnt=1, go to GRANT.
  - Otherwise stay in IDLE with outputs 0.
- State GRANT (g = current index). Rules are evaluated in this priority order:
  - a) req[g]==0 (release): set ptr=g+1 mod 4. If en && other requests are pending, grant the next pick (searching from g+1) on the same edge, so back-to-back grants have no idle cycle. Otherwise clear grant and go to IDLE.
  - b) MAX_HOLD!=0 && hold_cnt==MAX_HOLD: clear grant, pulse preempt=1, set ptr=g+1 mod 4, go to IDLE. The next grant needs one IDLE cycle. Requester g, if still requesting, now has lowest priority.
  - c) Otherwise: hold grant and increment hold_cnt, saturating at 2**HOLD_W-1.
- en low while in GRANT: the current grant persists under rules a–c, but no re-grant happens on release.
- The grant never changes to a different index without passing through a release or preempt decision. The grant is never multi-hot.
- Requests asserted and dropped within the same cycle that grant is registered are still granted for at least one cycle.
- Simultaneous release and hold-limit: release wins and preempt stays 0.
- preempt is low in every cycle except the single post-preempt cycle.

Decomposition:
- Package arb_pkg:
  - N_REQ=4, IDX_W=2.
  - state enum {IDLE, GRANT}.
  - function onehot2idx used for grant_idx.
- One combinational sub-module, rr_pick4:
  - Inputs: req[3:0], ptr[1:0], mask_idx[1:0], mask_en.
  - Outputs: pick_oh[3:0], pick_idx[1:0], pick_any.
  - rr_arbiter4 instantiates it once. mask_en excludes the releasing requester from the back-to-back search.

Test Plan:
- Single request: reset, en=1, req=4'b0100 → next cycle grant=0100, grant_idx=2, grant_valid=1. Drop req → next cycle grant=0, grant_valid=0.
- Rotation: en=1, req=1111 held, each owner drops its bit for one cycle on release → grant sequence 0001, 0010, 0100, 1000, 0001 with no idle cycles between grants.
- Hold limit: MAX_HOLD=4, req=0011 held continuously → grant=0001 for exactly 4 cycles. Then 1 cycle with grant=0 and preempt=1, then grant=0010.
- Enable gating: grant=0010 active, en=0, release req[1] while req[3]=1 → grant=0 and stays 0. Raise en=1 → grant=1000 one cycle later.
- Reset mid-grant: grant=1000 held, rst=1 for one cycle → next edge all outputs 0. After rst=0 with req=1001 → grant=0001, since ptr was reset to 0.
- Release/limit collision: MAX_HOLD=3, drop the owner's req exactly when hold_cnt==3 → preempt stays 0 and the next requester is granted back-to-back.
